// File: rtl/axi_master_pkg.sv
// Shared definitions for the AXI master blocks: FSM encoding, AXI encodings
// and the write request payload.
package axi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_RESP      = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  // Zero-width user fields are carried as a single tied-off bit.
  function automatic int eff_width(int w);
    return (w > 0) ? w : 1;
  endfunction

  // Word-aligned target address; the sum wraps modulo 2^32.
  function automatic logic [31:0] target_addr(logic [31:0] base, logic [31:0] offset);
    return base + {offset[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// AXI4 write-direction channels (AW, W, B) with master and slave views.
interface axi_write_master_if #(
    parameter int ID_WIDTH     = 1,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int AWUSER_WIDTH = 0,
    parameter int WUSER_WIDTH  = 0,
    parameter int BUSER_WIDTH  = 0
);
    localparam int AWU_W = (AWUSER_WIDTH > 0) ? AWUSER_WIDTH : 1;
    localparam int WU_W  = (WUSER_WIDTH > 0) ? WUSER_WIDTH : 1;
    localparam int BU_W  = (BUSER_WIDTH > 0) ? BUSER_WIDTH : 1;

    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [AWU_W-1:0]        awuser;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [WU_W-1:0]         wuser;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [BU_W-1:0]         buser;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
        input  awready, wready, bid, bresp, buser, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
        output awready, wready, bid, bresp, buser, bvalid
    );
endinterface

// File: rtl/axi_watchdog_counter.sv
// Sticky watchdog: counts cycles while run is high, raises expired on reaching LIMIT.
// The count restarts at 1 on clear so the request cycle itself counts toward the limit.
module axi_watchdog_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear) begin
            cnt_d = CNT_W'(1);
        end else if (run && cnt_q != CNT_W'(LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (run && cnt_d == CNT_W'(LIMIT)) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= CNT_W'(1);
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;
endmodule

// File: rtl/axi_write_master.sv
// Single-beat AXI4 write initiator: one INCR beat on AW/W, B response returned as status.
// Optional watchdog enabled by defining AXI_WRITE_TIMEOUT_EN.
module axi_write_master
    import axi_master_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_AXI_AWUSER_WIDTH       = 0,
    parameter int          C_M_AXI_WUSER_WIDTH        = 0,
    parameter int          C_M_AXI_BUSER_WIDTH        = 0,
    parameter int unsigned C_TIMEOUT_CYCLES           = 1024
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic                      write_request,
    input  logic [31:0]               write_address,
    input  logic [31:0]               write_data,
    input  logic [3:0]                write_strobe,
    output logic                      write_busy,
    output logic                      write_done,
    output logic [1:0]                write_resp,
    output logic                      write_dropped,
    output logic                      write_timeout,
    axi_write_master_if.master        m_axi
);
    localparam int AWU_W = eff_width(C_M_AXI_AWUSER_WIDTH);
    localparam int WU_W  = eff_width(C_M_AXI_WUSER_WIDTH);
    localparam int BU_W  = eff_width(C_M_AXI_BUSER_WIDTH);

    state_e     state_q, state_d;
    wr_req_t    req_q, req_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] resp_q, resp_d;
    logic       dropped_q, dropped_d;

    // NOTE: every always_comb output gets its default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_d    = resp_q;
        dropped_d = write_request && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (write_request) begin
                    req_d.addr = target_addr(C_M_TARGET_SLAVE_BASE_ADDR, write_address);
                    req_d.data = write_data;
                    req_d.strb = write_strobe;
                    state_d    = ST_ADDR_DATA;
                end
            end
            ST_ADDR_DATA: begin
                if (m_axi.awvalid && m_axi.awready) aw_done_d = 1'b1;
                if (m_axi.wvalid && m_axi.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= RESP_OKAY;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            dropped_q <= dropped_d;
        end
    end

    // Handshake outputs decode registered state only, so reset clears them at once.
    assign m_axi.awvalid = (state_q == ST_ADDR_DATA) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == ST_ADDR_DATA) && !w_done_q;
    assign m_axi.wlast   = m_axi.wvalid;
    assign m_axi.bready  = (state_q == ST_RESP);

    assign m_axi.awid    = C_M_AXI_ID_WIDTH'(0);
    assign m_axi.awaddr  = C_M_AXI_ADDR_WIDTH'(req_q.addr);
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = SIZE_4B;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = CACHE_DEFAULT;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awuser  = AWU_W'(0);
    assign m_axi.wdata   = C_M_AXI_DATA_WIDTH'(req_q.data);
    assign m_axi.wstrb   = req_q.strb;
    assign m_axi.wuser   = WU_W'(0);

    assign write_busy    = (state_q == ST_ADDR_DATA) || (state_q == ST_RESP);
    assign write_done    = (state_q == ST_DONE);
    assign write_resp    = resp_q;
    assign write_dropped = dropped_q;

    logic [C_M_AXI_ID_WIDTH-1:0] unused_bid;
    logic [BU_W-1:0]             unused_buser;
    assign unused_bid   = m_axi.bid;
    assign unused_buser = m_axi.buser;

`ifdef AXI_WRITE_TIMEOUT_EN
    axi_watchdog_counter #(
        .LIMIT(C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (M_AXI_ACLK),
        .rst    (M_AXI_ARESET),
        .clear  (state_q == ST_IDLE),
        .run    (write_busy),
        .expired(write_timeout)
    );
`else
    localparam int unsigned unused_timeout_cycles = C_TIMEOUT_CYCLES;
    assign write_timeout = 1'b0;
`endif
endmodule
